// File: rtl/time_set_controller_if.sv
// time_set_controller_if: button/seed inputs and time-keeper load outputs of the time-entry front end
//   btn_mode/btn_inc/btn_dec : debounced level buttons
//   curHH/curMM              : current time used to seed an edit
//   setHH/setMM/set          : load values and one-cycle load strobe
//   editing/edit_field/blink : display status while editing
interface time_set_controller_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic [6:0] curHH;
    logic [6:0] curMM;
    logic [6:0] setHH;
    logic [6:0] setMM;
    logic       set;
    logic       editing;
    logic [1:0] edit_field;
    logic       blink;
    modport master (
        output btn_mode, btn_inc, btn_dec, curHH, curMM,
        input  setHH, setMM, set, editing, edit_field, blink
    );
    modport slave (
        input  btn_mode, btn_inc, btn_dec, curHH, curMM,
        output setHH, setMM, set, editing, edit_field, blink
    );
endinterface

// File: rtl/time_set_controller.sv
// time_set_controller: button-driven HH:MM entry producing a one-cycle set strobe for the time keeper
//   clk_2MHz : system clock
//   reset    : asynchronous active-low reset
//   bus      : slave side of time_set_controller_if (buttons, seed time, load outputs, display status)
module time_set_controller #(
    parameter int unsigned REPEAT_DELAY = 1000000,
    parameter int unsigned REPEAT_RATE  = 200000,
    parameter int unsigned TIMEOUT_CYC  = 20000000,
    parameter int unsigned BLINK_CYC    = 500000
) (
    input logic                  clk_2MHz,
    input logic                  reset,
    time_set_controller_if.slave bus
);
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HOLD_W  = $clog2(HOLD_MAX + 1);
    localparam int IDLE_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int BLINK_W = $clog2(BLINK_CYC + 1);
    localparam logic [HOLD_W-1:0]  DELAY_HIT  = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0]  RATE_HIT   = HOLD_W'(REPEAT_RATE);
    localparam logic [IDLE_W-1:0]  TO_LAST    = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

    typedef enum logic [1:0] {IDLE, EDIT_HH, EDIT_MM, COMMIT} stateT;

    stateT              state;
    logic [6:0]         editHH, editMM;
    logic               armed, modePrev, incPrev, decPrev;
    logic [HOLD_W-1:0]  holdCnt;
    logic               repeating;
    logic [IDLE_W-1:0]  idleCnt;
    logic [BLINK_W-1:0] blinkCnt;
    logic               setQ, editingQ, blinkQ;
    logic [1:0]         fieldQ;
    logic               modePress, incPress, decPress, anyPress, inEdit, soloHeld;
    logic               repFire, stepUp, stepDn, step, timeout;
    logic [6:0]         hhNext, mmNext;

    assign bus.setHH      = editHH;
    assign bus.setMM      = editMM;
    assign bus.set        = setQ;
    assign bus.editing    = editingQ;
    assign bus.edit_field = fieldQ;
    assign bus.blink      = blinkQ;

    // armed stays low for the first clock after reset so a button held through release is not seen as a press
    always_comb begin
        modePress = armed & bus.btn_mode & ~modePrev;
        incPress  = armed & bus.btn_inc & ~incPrev;
        decPress  = armed & bus.btn_dec & ~decPrev;
        anyPress  = modePress | incPress | decPress;
        inEdit    = (state == EDIT_HH) || (state == EDIT_MM);
        soloHeld  = bus.btn_inc ^ bus.btn_dec;
        repFire   = inEdit & soloHeld & ~incPress & ~decPress & (holdCnt != '0) &
                    (holdCnt == (repeating ? RATE_HIT : DELAY_HIT));
        stepUp    = inEdit & ~modePress & ((incPress & ~decPress) | (repFire & bus.btn_inc));
        stepDn    = inEdit & ~modePress & ((decPress & ~incPress) | (repFire & bus.btn_dec));
        step      = stepUp | stepDn;
        timeout   = inEdit & ~anyPress & (idleCnt == TO_LAST);
        hhNext    = stepUp ? ((editHH == 7'd23) ? 7'd0 : editHH + 7'd1) :
                    stepDn ? ((editHH == 7'd0) ? 7'd23 : editHH - 7'd1) : editHH;
        mmNext    = stepUp ? ((editMM == 7'd59) ? 7'd0 : editMM + 7'd1) :
                    stepDn ? ((editMM == 7'd0) ? 7'd59 : editMM - 7'd1) : editMM;
    end

    always_ff @(posedge clk_2MHz or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            editHH    <= '0;
            editMM    <= '0;
            armed     <= 1'b0;
            modePrev  <= 1'b0;
            incPrev   <= 1'b0;
            decPrev   <= 1'b0;
            holdCnt   <= '0;
            repeating <= 1'b0;
            idleCnt   <= '0;
            blinkCnt  <= '0;
            setQ      <= 1'b0;
            editingQ  <= 1'b0;
            fieldQ    <= 2'b00;
            blinkQ    <= 1'b0;
        end else begin
            armed    <= 1'b1;
            modePrev <= bus.btn_mode;
            incPrev  <= bus.btn_inc;
            decPrev  <= bus.btn_dec;
            // hold timing only runs for a single button whose press was seen in an edit state
            if (!inEdit || !soloHeld || modePress) begin
                holdCnt   <= '0;
                repeating <= 1'b0;
            end else if (incPress || decPress) begin
                holdCnt   <= HOLD_W'(1);
                repeating <= 1'b0;
            end else if (repFire) begin
                holdCnt   <= HOLD_W'(1);
                repeating <= 1'b1;
            end else if (holdCnt != '0) begin
                holdCnt <= holdCnt + HOLD_W'(1);
            end
            idleCnt <= (!inEdit || anyPress) ? '0 : idleCnt + IDLE_W'(1);
            case (state)
                IDLE: begin
                    if (modePress) begin
                        state    <= EDIT_HH;
                        editHH   <= (bus.curHH > 7'd23) ? 7'd0 : bus.curHH;
                        editMM   <= (bus.curMM > 7'd59) ? 7'd0 : bus.curMM;
                        editingQ <= 1'b1;
                        fieldQ   <= 2'b01;
                        blinkQ   <= 1'b1;
                        blinkCnt <= '0;
                    end
                end
                EDIT_HH, EDIT_MM: begin
                    if (timeout) begin
                        state    <= IDLE;
                        editingQ <= 1'b0;
                        fieldQ   <= 2'b00;
                        blinkQ   <= 1'b0;
                        blinkCnt <= '0;
                    end else if (modePress && state == EDIT_HH) begin
                        state    <= EDIT_MM;
                        fieldQ   <= 2'b10;
                        blinkQ   <= 1'b1;
                        blinkCnt <= '0;
                    end else if (modePress) begin
                        state    <= COMMIT;
                        setQ     <= 1'b1;
                        editingQ <= 1'b0;
                        fieldQ   <= 2'b00;
                        blinkQ   <= 1'b0;
                        blinkCnt <= '0;
                    end else begin
                        if (state == EDIT_HH) editHH <= hhNext;
                        else editMM <= mmNext;
                        // a step restarts the blink period with the digit shown
                        blinkQ   <= step ? 1'b1 : (blinkCnt == BLINK_LAST) ? ~blinkQ : blinkQ;
                        blinkCnt <= (step || blinkCnt == BLINK_LAST) ? '0 : blinkCnt + BLINK_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    setQ  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller: directed checks of entry, wrap, auto-repeat, timeout, blink, simultaneous presses, seed clamp and reset
module tb_time_set_controller;
    logic       clk_2MHz = 1'b0;
    logic       reset = 1'b1;
    int         total = 0;
    int         bad = 0;
    int         setCnt = 0;

    time_set_controller_if tsIf();

    time_set_controller #(
        .REPEAT_DELAY(20),
        .REPEAT_RATE(5),
        .TIMEOUT_CYC(200),
        .BLINK_CYC(8)
    ) dut (
        .clk_2MHz(clk_2MHz),
        .reset(reset),
        .bus(tsIf)
    );

    always #5 clk_2MHz = ~clk_2MHz;

    always @(negedge clk_2MHz) if (tsIf.set === 1'b1) setCnt++;

    // inputs change and outputs are read 1 time unit after the rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk_2MHz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // m = {mode, inc, dec}; held for one sampling edge, then released for one
    task automatic press(input logic [2:0] m);
        tsIf.btn_mode = m[2];
        tsIf.btn_inc  = m[1];
        tsIf.btn_dec  = m[0];
        tick(1);
        tsIf.btn_mode = 1'b0;
        tsIf.btn_inc  = 1'b0;
        tsIf.btn_dec  = 1'b0;
        tick(1);
    endtask

    task automatic enter(input logic [6:0] hh, input logic [6:0] mm);
        tsIf.curHH = hh;
        tsIf.curMM = mm;
        press(3'b100);
    endtask

    task automatic commitChk(input string tag, input logic [6:0] hh, input logic [6:0] mm);
        tsIf.btn_mode = 1'b1;
        tick(1);
        chk({tag, " set"}, 32'(tsIf.set), 1);
        chk({tag, " setHH"}, 32'(tsIf.setHH), 32'(hh));
        chk({tag, " setMM"}, 32'(tsIf.setMM), 32'(mm));
        chk({tag, " field@commit"}, 32'(tsIf.edit_field), 0);
        tsIf.btn_mode = 1'b0;
        tick(1);
        chk({tag, " set low"}, 32'(tsIf.set), 0);
        chk({tag, " editing low"}, 32'(tsIf.editing), 0);
    endtask

    initial begin
        tsIf.btn_mode = 1'b0;
        tsIf.btn_inc  = 1'b0;
        tsIf.btn_dec  = 1'b0;
        tsIf.curHH    = 7'd0;
        tsIf.curMM    = 7'd0;
        #2 reset = 1'b0;
        tick(2);
        chk("rst editing", 32'(tsIf.editing), 0);
        chk("rst field", 32'(tsIf.edit_field), 0);
        chk("rst set", 32'(tsIf.set), 0);
        chk("rst blink", 32'(tsIf.blink), 0);
        chk("rst setHH", 32'(tsIf.setHH), 0);
        chk("rst setMM", 32'(tsIf.setMM), 0);
        reset = 1'b1;
        tick(2);
        // basic entry 10:30 -> 13:28
        enter(7'd10, 7'd30);
        chk("basic field hh", 32'(tsIf.edit_field), 1);
        chk("basic editing", 32'(tsIf.editing), 1);
        chk("basic seed hh", 32'(tsIf.setHH), 10);
        chk("basic seed mm", 32'(tsIf.setMM), 30);
        press(3'b010);
        chk("basic inc1 hh", 32'(tsIf.setHH), 11);
        chk("basic blink after step", 32'(tsIf.blink), 1);
        press(3'b010);
        press(3'b010);
        chk("basic inc3 hh", 32'(tsIf.setHH), 13);
        press(3'b100);
        chk("basic field mm", 32'(tsIf.edit_field), 2);
        press(3'b001);
        press(3'b001);
        chk("basic dec2 mm", 32'(tsIf.setMM), 28);
        chk("basic no set yet", 32'(setCnt), 0);
        commitChk("basic", 7'd13, 7'd28);
        chk("basic one set", 32'(setCnt), 1);
        // wrap up 23:59 -> 00:00
        enter(7'd23, 7'd59);
        press(3'b010);
        chk("wrap hh up", 32'(tsIf.setHH), 0);
        press(3'b100);
        press(3'b010);
        chk("wrap mm up", 32'(tsIf.setMM), 0);
        commitChk("wrapup", 7'd0, 7'd0);
        // wrap down 00:00 -> 23:59
        enter(7'd0, 7'd0);
        press(3'b001);
        chk("wrap hh down", 32'(tsIf.setHH), 23);
        press(3'b100);
        press(3'b001);
        chk("wrap mm down", 32'(tsIf.setMM), 59);
        commitChk("wrapdn", 7'd23, 7'd59);
        // auto-repeat: inc high for 45 sampling edges (0..44) -> steps at 0,20,25,30,35,40
        enter(7'd0, 7'd0);
        press(3'b100);
        tsIf.btn_inc = 1'b1;
        tick(20);
        chk("rep before delay", 32'(tsIf.setMM), 1);
        tick(1);
        chk("rep first", 32'(tsIf.setMM), 2);
        tick(24);
        chk("rep held 45", 32'(tsIf.setMM), 6);
        tsIf.btn_inc = 1'b0;
        tick(30);
        chk("rep released", 32'(tsIf.setMM), 6);
        commitChk("rep", 7'd0, 7'd6);
        // blink half-period and timeout 200 cycles after last press
        tsIf.curHH = 7'd7;
        tsIf.curMM = 7'd15;
        tsIf.btn_mode = 1'b1;
        tick(1);
        tsIf.btn_mode = 1'b0;
        tick(7);
        chk("blink on 7", 32'(tsIf.blink), 1);
        tick(1);
        chk("blink off 8", 32'(tsIf.blink), 0);
        tick(8);
        chk("blink on 16", 32'(tsIf.blink), 1);
        tsIf.btn_inc = 1'b1;
        tick(1);
        chk("to step", 32'(tsIf.setHH), 8);
        tsIf.btn_inc = 1'b0;
        tick(199);
        chk("to still editing", 32'(tsIf.editing), 1);
        tick(1);
        chk("to idle", 32'(tsIf.editing), 0);
        chk("to field", 32'(tsIf.edit_field), 0);
        chk("to blink", 32'(tsIf.blink), 0);
        chk("to keep hh", 32'(tsIf.setHH), 8);
        chk("to no set", 32'(setCnt), 4);
        // simultaneous presses
        enter(7'd5, 7'd5);
        press(3'b011);
        chk("incdec no step", 32'(tsIf.setHH), 5);
        chk("incdec field", 32'(tsIf.edit_field), 1);
        press(3'b110);
        chk("modeinc field", 32'(tsIf.edit_field), 2);
        chk("modeinc hh", 32'(tsIf.setHH), 5);
        chk("modeinc mm", 32'(tsIf.setMM), 5);
        commitChk("simul", 7'd5, 7'd5);
        // seed clamp
        enter(7'd30, 7'd45);
        chk("clamp hh", 32'(tsIf.setHH), 0);
        chk("clamp mm keep", 32'(tsIf.setMM), 45);
        // reset mid-edit with mode held through release
        press(3'b100);
        chk("rm field mm", 32'(tsIf.edit_field), 2);
        tsIf.btn_mode = 1'b1;
        reset = 1'b0;
        #2;
        chk("rm async editing", 32'(tsIf.editing), 0);
        chk("rm async field", 32'(tsIf.edit_field), 0);
        chk("rm async blink", 32'(tsIf.blink), 0);
        chk("rm async hh", 32'(tsIf.setHH), 0);
        chk("rm async mm", 32'(tsIf.setMM), 0);
        tick(2);
        reset = 1'b1;
        tick(3);
        chk("rm held no event", 32'(tsIf.editing), 0);
        tsIf.btn_mode = 1'b0;
        tick(1);
        enter(7'd12, 7'd60);
        chk("rm repress field", 32'(tsIf.edit_field), 1);
        chk("rm seed hh", 32'(tsIf.setHH), 12);
        chk("rm clamp mm", 32'(tsIf.setMM), 0);
        chk("set count", 32'(setCnt), 5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
